// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller over a simple dual-port RAM with a 2-entry registered output buffer.
// Reads are prefetched into the buffer so the head word never comes combinationally from the RAM.
module ram_fifo_ctrl #(
  parameter int WIDTH = 32,
  parameter int ADDR  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WIDTH-1:0]  s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WIDTH-1:0]  m_data,
  output logic [ADDR+1:0]   count,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR-1:0]   ram_addra,
  output logic [WIDTH-1:0]  ram_dina,
  output logic              ram_enb,
  output logic              ram_web,
  output logic [ADDR-1:0]   ram_addrb,
  input  logic [WIDTH-1:0]  ram_doutb
);
  localparam logic [ADDR:0] DEPTH = (ADDR+1)'(1) << ADDR;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t            state_q, state_d;
  logic [ADDR:0]     wr_ptr_q, rd_ptr_q, used;
  logic [ADDR+1:0]   count_q;
  logic [WIDTH-1:0]  b0_q, b1_q, b0_d, b1_d;
  logic              inflight_q, rdy_q, wr, rd, pop;
  logic [2:0]        occ;
  assign used      = wr_ptr_q - rd_ptr_q;
  assign s_ready   = rdy_q && (used != DEPTH);
  assign wr        = s_valid && s_ready;
  assign m_valid   = state_q != EMPTY;
  assign pop       = m_valid && m_ready;
  assign occ       = state_q == TWO ? 3'd2 : state_q == ONE ? 3'd1 : 3'd0;
  // Prefetch only while the in-flight word plus buffered words will still fit after this pop.
  assign rd        = (used != '0) && (3'(inflight_q) + occ - 3'(pop) < 3'd2);
  assign ram_ena   = wr;
  assign ram_wea   = wr;
  assign ram_addra = wr_ptr_q[ADDR-1:0];
  assign ram_dina  = wr ? s_data : '0;
  assign ram_enb   = rd;
  assign ram_web   = 1'b0;
  assign ram_addrb = rd_ptr_q[ADDR-1:0];
  assign m_data    = b0_q;
  assign count     = count_q;
  always_comb begin
    state_d = state_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    if (inflight_q && !pop) begin
      state_d = state_q == EMPTY ? ONE : TWO;
      b0_d    = state_q == EMPTY ? ram_doutb : b0_q;
      b1_d    = state_q == EMPTY ? b1_q : ram_doutb;
    end else if (!inflight_q && pop) begin
      state_d = state_q == TWO ? ONE : EMPTY;
      b0_d    = state_q == TWO ? b1_q : b0_q;
    end else if (inflight_q && pop) begin
      b0_d    = state_q == TWO ? b1_q : ram_doutb;
      b1_d    = state_q == TWO ? ram_doutb : b1_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      rdy_q      <= 1'b0;
      state_q    <= EMPTY;
      b0_q       <= '0;
      b1_q       <= '0;
      count_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_q + (ADDR+1)'(wr);
      rd_ptr_q   <= rd_ptr_q + (ADDR+1)'(rd);
      inflight_q <= rd;
      rdy_q      <= 1'b1;
      state_q    <= state_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      count_q    <= count_q + (ADDR+2)'(wr) - (ADDR+2)'(pop);
    end
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed and random checks of ram_fifo_ctrl against a queue-based FIFO model.
module tb_ram_fifo_ctrl;
  localparam int WIDTH = 32;
  localparam int ADDR  = 10;
  logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic s_ready, m_valid, ram_ena, ram_wea, ram_enb, ram_web;
  logic [WIDTH-1:0] s_data = '0, m_data, ram_dina, ram_doutb;
  logic [ADDR+1:0] count;
  logic [ADDR-1:0] ram_addra, ram_addrb;
  logic [WIDTH-1:0] mem [2**ADDR];
  logic [WIDTH-1:0] q [$];
  int n_assert = 0, n_fail = 0;
  int cyc = 0, reads_n = 0, pops_n = 0, first_cyc = 0, last_cyc = 0;
  logic last_wr;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.WIDTH(WIDTH), .ADDR(ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .count(count),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_enb(ram_enb), .ram_web(ram_web), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb));

  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_enb) ram_doutb <= mem[ram_addrb];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at the falling edge, update the model, then check count after the rising edge.
  task automatic cycle();
    @(negedge clk);
    last_wr = s_valid && s_ready;
    reads_n += int'(ram_enb);
    if (ram_ena && ram_enb) chk("rd_wr_same_addr", 64'(ram_addra == ram_addrb), 64'd0);
    if (m_valid) begin
      chk("m_valid_with_data", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) chk("m_data_head", 64'(m_data), 64'(q[0]));
    end
    if (m_valid && m_ready && q.size() != 0) begin
      void'(q.pop_front());
      if (pops_n == 0) first_cyc = cyc;
      last_cyc = cyc;
      pops_n++;
    end
    if (last_wr) q.push_back(s_data);
    @(posedge clk);
    #1;
    cyc++;
    chk("count", 64'(count), 64'(q.size()));
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 5000 && q.size() != 0; k++) cycle();
    chk("drain_empty", 64'(q.size()), 64'd0);
    cycle();
    chk("drained_m_valid", 64'(m_valid), 64'd0);
  endtask

  initial begin
    int idx;
    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_ram", 64'({ram_ena, ram_wea, ram_enb, ram_web, ram_addra, ram_addrb, ram_dina}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("s_ready_before_edge", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("s_ready_after_edge", 64'(s_ready), 64'd1);

    // single word latency
    s_valid = 1'b1;
    s_data = 32'hA5A5A5A5;
    cycle();
    s_valid = 1'b0;
    chk("lat_e0_m_valid", 64'(m_valid), 64'd0);
    cycle();
    chk("lat_e1_m_valid", 64'(m_valid), 64'd0);
    cycle();
    chk("lat_e2_m_valid", 64'(m_valid), 64'd1);
    chk("lat_e2_m_data", 64'(m_data), 64'hA5A5A5A5);
    chk("lat_e2_count", 64'(count), 64'd1);
    cycle();
    chk("hold_m_data", 64'(m_data), 64'hA5A5A5A5);
    drain();

    // fill to capacity with the sink stalled
    m_ready = 1'b0;
    reads_n = 0;
    for (int i = 0; i < 1026; i++) begin
      chk("fill_s_ready", 64'(s_ready), 64'd1);
      s_valid = 1'b1;
      s_data = 32'(i);
      cycle();
    end
    chk("full_s_ready", 64'(s_ready), 64'd0);
    chk("full_count", 64'(count), 64'd1026);
    s_data = 32'hDEAD;
    cycle();
    chk("full_count_hold", 64'(count), 64'd1026);
    chk("full_reads", 64'(reads_n), 64'd2);
    drain();

    // continuous streaming across pointer wrap
    pops_n = 0;
    idx = 0;
    m_ready = 1'b1;
    for (int k = 0; k < 4000 && idx < 3000; k++) begin
      s_valid = 1'b1;
      s_data = 32'(idx);
      cycle();
      if (last_wr) idx++;
    end
    chk("stream_writes", 64'(idx), 64'd3000);
    drain();
    chk("stream_pops", 64'(pops_n), 64'd3000);
    chk("stream_no_bubble", 64'(last_cyc - first_cyc), 64'd2999);

    // random traffic
    idx = 0;
    for (int k = 0; k < 60000 && idx < 10000; k++) begin
      s_valid = $urandom_range(0, 3) != 0;
      m_ready = $urandom_range(0, 3) != 0;
      s_data = $urandom;
      cycle();
      if (last_wr) idx++;
    end
    chk("rand_writes", 64'(idx), 64'd10000);
    drain();

    // reset with contents stored
    m_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      s_valid = 1'b1;
      s_data = 32'(i + 100);
      cycle();
    end
    s_valid = 1'b0;
    chk("pre_reset_count", 64'(count), 64'd300);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data = 32'h1;
    cycle();
    s_valid = 1'b0;
    cycle();
    cycle();
    chk("post_rst_m_valid", 64'(m_valid), 64'd1);
    chk("post_rst_m_data", 64'(m_data), 64'h1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
